reorder_buffer: RTL and testbench

//  In-order commit queue of the OoO core; the producer side of the register file's commit/query interface.

---
 rtl/reorder_buffer_pkg.sv | 34 +++
 rtl/reorder_buffer_if.sv | 61 ++++++
 rtl/reorder_buffer.sv | 127 ++++++++++++
 tb/tb_reorder_buffer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry encoding and helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_W = 5;
  localparam int unsigned DEPTH = 1 << ROB_W;
  localparam int unsigned CNT_W = ROB_W + 1;
  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;

  typedef logic [ROB_W-1:0] rob_id_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_type_e;

  // One ROB slot; for BRANCH entries value holds the alternate (non-predicted) PC.
  typedef struct packed {
    rob_type_e        typ;
    logic [REG_W-1:0] rd;
    logic             ready;
    logic [XLEN-1:0]  value;
    logic             pred;
    logic             taken;
  } rob_entry_t;

  // Circular pointer advance; wraps DEPTH-1 -> 0 by width.
  function automatic rob_id_t rob_inc(rob_id_t id);
    return id + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, query and commit signals between the ROB and the core.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             issue_valid;
  rob_type_e        issue_type;
  logic [REG_W-1:0] issue_rd;
  logic             issue_ready;
  logic [XLEN-1:0]  issue_value;
  logic             issue_pred;
  logic             rob_full;
  rob_id_t          tail_id;
  logic             rf_set_dep;
  logic [REG_W-1:0] rf_dep_reg_id;
  rob_id_t          rf_dep_rob_id;

  logic             alu_valid;
  rob_id_t          alu_id;
  logic [XLEN-1:0]  alu_value;
  logic             alu_taken;
  logic             lsb_valid;
  rob_id_t          lsb_id;
  logic [XLEN-1:0]  lsb_value;

  rob_id_t          qry_id1;
  rob_id_t          qry_id2;
  logic             qry_ready1;
  logic             qry_ready2;
  logic [XLEN-1:0]  qry_value1;
  logic [XLEN-1:0]  qry_value2;

  logic             rf_set_value;
  logic [REG_W-1:0] rf_value_reg_id;
  logic [XLEN-1:0]  rf_value;
  rob_id_t          rf_value_rob_id;
  logic             store_commit;
  rob_id_t          store_rob_id;
  logic             clear;
  logic [XLEN-1:0]  clear_pc;

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_ready, issue_value, issue_pred,
    input  alu_valid, alu_id, alu_value, alu_taken, lsb_valid, lsb_id, lsb_value,
    input  qry_id1, qry_id2,
    output rob_full, tail_id, rf_set_dep, rf_dep_reg_id, rf_dep_rob_id,
    output qry_ready1, qry_ready2, qry_value1, qry_value2,
    output rf_set_value, rf_value_reg_id, rf_value, rf_value_rob_id,
    output store_commit, store_rob_id, clear, clear_pc
  );

  modport master (
    output issue_valid, issue_type, issue_rd, issue_ready, issue_value, issue_pred,
    output alu_valid, alu_id, alu_value, alu_taken, lsb_valid, lsb_id, lsb_value,
    output qry_id1, qry_id2,
    input  rob_full, tail_id, rf_set_dep, rf_dep_reg_id, rf_dep_rob_id,
    input  qry_ready1, qry_ready2, qry_value1, qry_value2,
    input  rf_set_value, rf_value_reg_id, rf_value, rf_value_rob_id,
    input  store_commit, store_rob_id, clear, clear_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates at tail, captures ALU/LSB results, retires one
// entry per cycle from head and raises a one-cycle machine clear on a mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  reorder_buffer_if.slave bus
);

  logic [DEPTH-1:0] r_busy;
  rob_entry_t       r_entry [DEPTH];
  rob_id_t          r_head;
  rob_id_t          r_tail;
  rob_cnt_t         r_count;
  logic             r_clear;
  logic [XLEN-1:0]  r_clear_pc;

  rob_entry_t w_head_ent;
  logic       w_full;
  logic       w_issue;
  logic       w_commit;
  logic       w_mispredict;

  assign w_head_ent   = r_entry[r_head];
  assign w_full       = (r_count == rob_cnt_t'(DEPTH));
  assign w_issue      = bus.issue_valid & ~w_full & rdy & ~r_clear;
  assign w_commit     = r_busy[r_head] & w_head_ent.ready & rdy & ~r_clear;
  assign w_mispredict = w_commit & (w_head_ent.typ == ROB_BRANCH) &
                        (w_head_ent.taken != w_head_ent.pred);

  assign bus.rob_full        = w_full;
  assign bus.tail_id         = r_tail;
  assign bus.rf_set_dep      = bus.issue_valid & (bus.issue_type == ROB_REG) &
                               (bus.issue_rd != '0) & ~r_clear & rdy;
  assign bus.rf_dep_reg_id   = bus.issue_rd;
  assign bus.rf_dep_rob_id   = r_tail;
  assign bus.rf_set_value    = w_commit & (w_head_ent.typ == ROB_REG) & (w_head_ent.rd != '0);
  assign bus.rf_value_reg_id = w_head_ent.rd;
  assign bus.rf_value        = w_head_ent.value;
  assign bus.rf_value_rob_id = r_head;
  assign bus.store_commit    = w_commit & (w_head_ent.typ == ROB_STORE);
  assign bus.store_rob_id    = r_head;
  assign bus.clear           = r_clear;
  assign bus.clear_pc        = r_clear_pc;

  // Register-file lookups with same-cycle bypass; ALU bus outranks LSB bus outranks entry.
  always_comb begin
    bus.qry_ready1 = r_entry[bus.qry_id1].ready;
    bus.qry_value1 = r_entry[bus.qry_id1].value;
    bus.qry_ready2 = r_entry[bus.qry_id2].ready;
    bus.qry_value2 = r_entry[bus.qry_id2].value;
    if (bus.lsb_valid && (bus.lsb_id == bus.qry_id1)) begin
      bus.qry_ready1 = 1'b1;
      bus.qry_value1 = bus.lsb_value;
    end
    if (bus.alu_valid && (bus.alu_id == bus.qry_id1)) begin
      bus.qry_ready1 = 1'b1;
      bus.qry_value1 = bus.alu_value;
    end
    if (bus.lsb_valid && (bus.lsb_id == bus.qry_id2)) begin
      bus.qry_ready2 = 1'b1;
      bus.qry_value2 = bus.lsb_value;
    end
    if (bus.alu_valid && (bus.alu_id == bus.qry_id2)) begin
      bus.qry_ready2 = 1'b1;
      bus.qry_value2 = bus.alu_value;
    end
  end

  // Queue state: clear cycle idles, mispredict flushes, otherwise writeback/commit/issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_clear    <= 1'b0;
      r_clear_pc <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (rdy) begin
      if (r_clear) begin
        r_clear <= 1'b0;
      end else if (w_mispredict) begin
        r_clear    <= 1'b1;
        r_clear_pc <= w_head_ent.value;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_busy     <= '0;
      end else begin
        if (bus.lsb_valid && r_busy[bus.lsb_id]) begin
          r_entry[bus.lsb_id].ready <= 1'b1;
          r_entry[bus.lsb_id].value <= bus.lsb_value;
        end
        if (bus.alu_valid && r_busy[bus.alu_id]) begin
          r_entry[bus.alu_id].ready <= 1'b1;
          r_entry[bus.alu_id].value <= bus.alu_value;
          r_entry[bus.alu_id].taken <= bus.alu_taken;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= rob_inc(r_head);
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_entry[r_tail] <= '{typ:   bus.issue_type,
                               rd:    bus.issue_rd,
                               ready: bus.issue_ready,
                               value: bus.issue_value,
                               pred:  bus.issue_pred,
                               taken: 1'b0};
          r_tail          <= rob_inc(r_tail);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + rob_cnt_t'(1);
          2'b01:   r_count <= r_count - rob_cnt_t'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: queue-based model checked every cycle plus literal pins.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  int   checks;
  int   errors;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  id;
    rob_type_e   typ;
    logic [4:0]  rd;
    bit          ready;
    logic [31:0] value;
    bit          pred;
    bit          taken;
  } ment_t;

  ment_t       q[$];
  logic [4:0]  mtail;
  bit          mclear;
  logic [31:0] mclear_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mtail     = '0;
    mclear    = 1'b0;
    mclear_pc = '0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_update();
    bit    commit;
    bit    full;
    ment_t e;
    if (!rdy) return;
    if (mclear) begin
      mclear = 1'b0;
      return;
    end
    commit = (q.size() > 0) && q[0].ready;
    if (commit && q[0].typ == ROB_BRANCH && q[0].taken != q[0].pred) begin
      mclear_pc = q[0].value;
      mclear    = 1'b1;
      q.delete();
      mtail     = '0;
      return;
    end
    full = (q.size() == DEPTH);
    foreach (q[i]) begin
      e = q[i];
      if (bus.lsb_valid && e.id == bus.lsb_id) begin
        e.ready = 1'b1;
        e.value = bus.lsb_value;
      end
      if (bus.alu_valid && e.id == bus.alu_id) begin
        e.ready = 1'b1;
        e.value = bus.alu_value;
        e.taken = bus.alu_taken;
      end
      q[i] = e;
    end
    if (commit) void'(q.pop_front());
    if (bus.issue_valid && !full) begin
      e.id    = mtail;
      e.typ   = bus.issue_type;
      e.rd    = bus.issue_rd;
      e.ready = bus.issue_ready;
      e.value = bus.issue_value;
      e.pred  = bus.issue_pred;
      e.taken = 1'b0;
      q.push_back(e);
      mtail = mtail + 5'd1;
    end
  endtask

  task automatic qry_chk(input string n, input logic [4:0] id, input logic act_rdy,
                         input logic [31:0] act_val);
    bit          live;
    bit          lr;
    logic [31:0] lv;
    bit          ah;
    bit          lh;
    bit          exp_rdy;
    live = 1'b0;
    lr   = 1'b0;
    lv   = '0;
    foreach (q[i]) begin
      if (q[i].id == id) begin
        live = 1'b1;
        lr   = q[i].ready;
        lv   = q[i].value;
      end
    end
    ah = bus.alu_valid && (bus.alu_id == id);
    lh = bus.lsb_valid && (bus.lsb_id == id);
    if (live || ah || lh) begin
      exp_rdy = lr || ah || lh;
      chk({n, "_ready"}, 32'(act_rdy), 32'(exp_rdy));
      if (exp_rdy) chk({n, "_value"}, act_val, ah ? bus.alu_value : (lh ? bus.lsb_value : lv));
    end
  endtask

  // Compare every DUT output against the model while out of reset.
  task automatic compare();
    bit commit;
    bit set_dep;
    bit setv;
    bit st;
    chk("rob_full", 32'(bus.rob_full), 32'(q.size() == DEPTH));
    chk("tail_id", 32'(bus.tail_id), 32'(mtail));
    chk("clear", 32'(bus.clear), 32'(mclear));
    if (mclear) chk("clear_pc", bus.clear_pc, mclear_pc);
    set_dep = bus.issue_valid && bus.issue_type == ROB_REG && bus.issue_rd != 5'd0 && !mclear && rdy;
    chk("rf_set_dep", 32'(bus.rf_set_dep), 32'(set_dep));
    if (set_dep) begin
      chk("rf_dep_reg_id", 32'(bus.rf_dep_reg_id), 32'(bus.issue_rd));
      chk("rf_dep_rob_id", 32'(bus.rf_dep_rob_id), 32'(mtail));
    end
    commit = !mclear && rdy && (q.size() > 0) && q[0].ready;
    setv   = commit && q[0].typ == ROB_REG && q[0].rd != 5'd0;
    st     = commit && q[0].typ == ROB_STORE;
    chk("rf_set_value", 32'(bus.rf_set_value), 32'(setv));
    if (setv) begin
      chk("rf_value_reg_id", 32'(bus.rf_value_reg_id), 32'(q[0].rd));
      chk("rf_value", bus.rf_value, q[0].value);
      chk("rf_value_rob_id", 32'(bus.rf_value_rob_id), 32'(q[0].id));
    end
    chk("store_commit", 32'(bus.store_commit), 32'(st));
    if (st) chk("store_rob_id", 32'(bus.store_rob_id), 32'(q[0].id));
    qry_chk("qry1", bus.qry_id1, bus.qry_ready1, bus.qry_value1);
    qry_chk("qry2", bus.qry_id2, bus.qry_ready2, bus.qry_value2);
  endtask

  always @(posedge clk) if (!rst) model_update();

  always @(negedge clk) begin
    #2;
    if (!rst) compare();
  end

  task automatic idle();
    rdy             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_type  = ROB_REG;
    bus.issue_rd    = '0;
    bus.issue_ready = 1'b0;
    bus.issue_value = '0;
    bus.issue_pred  = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.alu_id      = '0;
    bus.alu_value   = '0;
    bus.alu_taken   = 1'b0;
    bus.lsb_valid   = 1'b0;
    bus.lsb_id      = '0;
    bus.lsb_value   = '0;
    bus.qry_id1     = '0;
    bus.qry_id2     = '0;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic do_issue(input rob_type_e t, input logic [4:0] rd, input bit r,
                          input logic [31:0] v, input bit pred);
    bus.issue_valid = 1'b1;
    bus.issue_type  = t;
    bus.issue_rd    = rd;
    bus.issue_ready = r;
    bus.issue_value = v;
    bus.issue_pred  = pred;
  endtask

  task automatic do_alu(input logic [4:0] id, input logic [31:0] v, input bit taken);
    bus.alu_valid = 1'b1;
    bus.alu_id    = id;
    bus.alu_value = v;
    bus.alu_taken = taken;
  endtask

  task automatic do_lsb(input logic [4:0] id, input logic [31:0] v);
    bus.lsb_valid = 1'b1;
    bus.lsb_id    = id;
    bus.lsb_value = v;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    idle();
    model_reset();
    #1;
    chk("reset_rob_full", 32'(bus.rob_full), 32'd0);
    chk("reset_tail_id", 32'(bus.tail_id), 32'd0);
    chk("reset_clear", 32'(bus.clear), 32'd0);
    chk("reset_clear_pc", bus.clear_pc, 32'd0);
    next();
    next();
    rst = 1'b0;

    // REG rd5 at id0, ALU writes 0x1234, commits the following cycle
    do_issue(ROB_REG, 5'd5, 1'b0, 32'd0, 1'b0);
    #3 chk("t1_tail", 32'(bus.tail_id), 32'd0);
    chk("t1_set_dep", 32'(bus.rf_set_dep), 32'd1);
    chk("t1_dep_rob", 32'(bus.rf_dep_rob_id), 32'd0);
    next();
    do_alu(5'd0, 32'h1234, 1'b0);
    bus.qry_id1 = 5'd0;
    #3 chk("t1_qry_rdy", 32'(bus.qry_ready1), 32'd1);
    chk("t1_qry_val", bus.qry_value1, 32'h1234);
    next();
    #3 chk("t1_setv", 32'(bus.rf_set_value), 32'd1);
    chk("t1_reg", 32'(bus.rf_value_reg_id), 32'd5);
    chk("t1_val", bus.rf_value, 32'h1234);
    chk("t1_robid", 32'(bus.rf_value_rob_id), 32'd0);

    // ids 1..3, dual writeback and query bypass
    next(); do_issue(ROB_REG, 5'd7, 1'b0, 32'd0, 1'b0);
    next(); do_issue(ROB_REG, 5'd8, 1'b0, 32'd0, 1'b0);
    next(); do_issue(ROB_REG, 5'd9, 1'b0, 32'd0, 1'b0);
    next();
    do_alu(5'd3, 32'hAB, 1'b0);
    do_lsb(5'd2, 32'h55);
    bus.qry_id1 = 5'd3;
    bus.qry_id2 = 5'd2;
    #3 chk("byp_rdy1", 32'(bus.qry_ready1), 32'd1);
    chk("byp_val1", bus.qry_value1, 32'hAB);
    chk("byp_rdy2", 32'(bus.qry_ready2), 32'd1);
    chk("byp_val2", bus.qry_value2, 32'h55);
    next();
    bus.qry_id1 = 5'd1;
    bus.qry_id2 = 5'd3;
    #3 chk("q_notready", 32'(bus.qry_ready1), 32'd0);
    chk("q_stored_rdy", 32'(bus.qry_ready2), 32'd1);
    chk("q_stored_val", bus.qry_value2, 32'hAB);
    chk("head_blocked", 32'(bus.rf_set_value), 32'd0);
    next(); do_alu(5'd1, 32'h11, 1'b0);
    next(); #3 chk("c1_val", bus.rf_value, 32'h11);
    next(); #3 chk("c2_val", bus.rf_value, 32'h55);
    next(); #3 chk("c3_val", bus.rf_value, 32'hAB);
    chk("c3_robid", 32'(bus.rf_value_rob_id), 32'd3);

    // rdy low freezes a ready head for three cycles
    next(); do_issue(ROB_REG, 5'd10, 1'b1, 32'h77, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next();
      rdy = 1'b0;
      do_issue(ROB_REG, 5'd11, 1'b1, 32'h88, 1'b0);
      #3 chk("frz_setv", 32'(bus.rf_set_value), 32'd0);
      chk("frz_dep", 32'(bus.rf_set_dep), 32'd0);
      chk("frz_tail", 32'(bus.tail_id), 32'd5);
    end
    next();
    #3 chk("thaw_setv", 32'(bus.rf_set_value), 32'd1);
    chk("thaw_val", bus.rf_value, 32'h77);
    chk("thaw_robid", 32'(bus.rf_value_rob_id), 32'd4);

    // STORE id5 readied by LSB, then REG rd0 id6
    next(); do_issue(ROB_STORE, 5'd0, 1'b0, 32'd0, 1'b0);
    next(); do_issue(ROB_REG, 5'd0, 1'b1, 32'h99, 1'b0);
    #3 chk("rd0_dep", 32'(bus.rf_set_dep), 32'd0);
    next(); do_lsb(5'd5, 32'hDEAD);
    #3 chk("st_wait", 32'(bus.store_commit), 32'd0);
    next();
    #3 chk("st_commit", 32'(bus.store_commit), 32'd1);
    chk("st_id", 32'(bus.store_rob_id), 32'd5);
    next();
    #3 chk("rd0_setv", 32'(bus.rf_set_value), 32'd0);
    next();
    #3 chk("rd0_tail", 32'(bus.tail_id), 32'd7);

    // fill all 32 slots from id7 (tail wraps through 0)
    for (int i = 0; i < 32; i++) begin
      do_issue(ROB_REG, 5'((i % 31) + 1), 1'b0, 32'd0, 1'b0);
      if (i == 31) #3 chk("fill_notfull", 32'(bus.rob_full), 32'd0);
      next();
    end
    #3 chk("full", 32'(bus.rob_full), 32'd1);
    chk("full_tail", 32'(bus.tail_id), 32'd7);
    do_issue(ROB_REG, 5'd1, 1'b1, 32'h1, 1'b0);
    next();
    #3 chk("full_drop_tail", 32'(bus.tail_id), 32'd7);
    chk("full_hold", 32'(bus.rob_full), 32'd1);
    do_alu(5'd7, 32'hA7, 1'b0);
    do_lsb(5'd8, 32'hA8);
    next();
    #3 chk("f_c7", bus.rf_value, 32'hA7);
    chk("f_c7_id", 32'(bus.rf_value_rob_id), 32'd7);
    next();
    do_issue(ROB_REG, 5'd12, 1'b0, 32'd0, 1'b0);
    #3 chk("f_c8", bus.rf_value, 32'hA8);
    chk("f_31", 32'(bus.rob_full), 32'd0);
    next();
    #3 chk("f_same_cnt", 32'(bus.rob_full), 32'd0);
    chk("f_tail8", 32'(bus.tail_id), 32'd8);
    do_issue(ROB_REG, 5'd13, 1'b0, 32'd0, 1'b0);
    next();
    #3 chk("f_refull", 32'(bus.rob_full), 32'd1);
    chk("f_tail9", 32'(bus.tail_id), 32'd9);

    // reset mid-operation
    rst = 1'b1;
    model_reset();
    #1 chk("rst_mid_full", 32'(bus.rob_full), 32'd0);
    chk("rst_mid_tail", 32'(bus.tail_id), 32'd0);
    next();
    rst = 1'b0;

    // mispredicted branch flushes younger entries
    do_issue(ROB_BRANCH, 5'd0, 1'b0, 32'h100, 1'b0);
    next(); do_issue(ROB_REG, 5'd3, 1'b0, 32'd0, 1'b0);
    next(); do_issue(ROB_STORE, 5'd0, 1'b0, 32'd0, 1'b0);
    next(); do_alu(5'd0, 32'h100, 1'b1); do_lsb(5'd2, 32'h5);
    next();
    do_issue(ROB_REG, 5'd4, 1'b1, 32'h44, 1'b0);
    do_alu(5'd1, 32'h31, 1'b0);
    #3 chk("mp_pre_clear", 32'(bus.clear), 32'd0);
    next();
    rdy = 1'b0;
    do_issue(ROB_REG, 5'd4, 1'b1, 32'h44, 1'b0);
    #3 chk("mp_clear", 32'(bus.clear), 32'd1);
    chk("mp_pc", bus.clear_pc, 32'h100);
    chk("mp_tail", 32'(bus.tail_id), 32'd0);
    chk("mp_dep", 32'(bus.rf_set_dep), 32'd0);
    next();
    do_issue(ROB_REG, 5'd4, 1'b1, 32'h44, 1'b0);
    #3 chk("mp_clear_hold", 32'(bus.clear), 32'd1);
    chk("mp_dep_clr", 32'(bus.rf_set_dep), 32'd0);
    next();
    #3 chk("mp_clear_drop", 32'(bus.clear), 32'd0);
    chk("mp_tail_after", 32'(bus.tail_id), 32'd0);

    // correctly predicted branch retires quietly
    do_issue(ROB_BRANCH, 5'd0, 1'b0, 32'h200, 1'b1);
    next(); do_alu(5'd0, 32'h200, 1'b1);
    next(); #3 chk("bp_ok0", 32'(bus.clear), 32'd0);
    next(); #3 chk("bp_ok1", 32'(bus.clear), 32'd0);
    chk("bp_tail", 32'(bus.tail_id), 32'd1);

    // reset while clear is high cancels it
    do_issue(ROB_BRANCH, 5'd0, 1'b0, 32'h300, 1'b1);
    next(); do_alu(5'd1, 32'h300, 1'b0);
    next();
    next();
    #3 chk("rc_clear", 32'(bus.clear), 32'd1);
    chk("rc_pc", bus.clear_pc, 32'h300);
    rst = 1'b1;
    model_reset();
    #1 chk("rc_clear_gone", 32'(bus.clear), 32'd0);
    chk("rc_pc_gone", bus.clear_pc, 32'd0);
    next();
    rst = 1'b0;
    next();
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
